// File: rtl/uart_led_pkg.sv
// Shared definitions for the UART LED command parser.
//   - Command codes carried in the CMD byte of a frame.
//   - Response bytes returned to the UART transmitter.
//   - Frame-assembly FSM state encoding.
//   - Helper that says whether a CMD byte names a supported command.
package uart_led_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_SET    = 8'h02;
    localparam logic [7:0] CMD_CLR    = 8'h03;
    localparam logic [7:0] CMD_TOGGLE = 8'h04;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_e;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_SET) ||
               (cmd == CMD_CLR)   || (cmd == CMD_TOGGLE);
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync.sv
// Brings the receiver's done pulse into the clk domain and flags each
// received byte once.
//   clk, rst   : system clock, synchronous active-high reset
//   rx_data    : byte from the UART receiver
//   rx_done    : receiver done pulse (asynchronous to clk)
//   byte_acc   : one-cycle strobe on a synchronized falling edge of rx_done
//   byte_data  : the byte to accept while byte_acc is high
module uart_rx_byte_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       byte_acc,
    output logic [7:0] byte_data
);

    // s1/s2 form the two-flop synchronizer; s3 is edge-detect history.
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = rx_done;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let all flops sample the old values,
        // which is what makes this a shift chain rather than a single wire.
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Falling edge: the receiver has finished presenting the byte, and RxData
    // is stable from then until the next byte, so it is sampled directly.
    assign byte_acc  = s3_q & ~s2_q;
    assign byte_data = rx_data;

endmodule

// File: rtl/uart_led_cmd_parser.sv
// Assembles SYNC/CMD/DATA/CHK frames from the UART receiver, applies valid
// LED commands and returns a one-byte ACK/NAK.
//   Clk, Rst   : system clock, synchronous active-high reset
//   RxData     : received byte
//   RxDone     : receiver done pulse (byte taken on its synchronized fall)
//   Led        : LED register
//   RespData   : last response byte (ACK 8'h06 / NAK 8'h15), held
//   RespValid  : one-cycle strobe when a new response is presented
//   ErrCount   : saturating count of NAKs and inter-byte timeouts
//   Busy       : high while a frame is in progress
module uart_led_cmd_parser #(
    parameter int unsigned LED_WIDTH      = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [7:0]           RxData,
    input  logic                 RxDone,
    output logic [LED_WIDTH-1:0] Led,
    output logic [7:0]           RespData,
    output logic                 RespValid,
    output logic [7:0]           ErrCount,
    output logic                 Busy
);

    import uart_led_pkg::*;

    localparam int unsigned    TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic       byte_acc;
    logic [7:0] byte_data;

    uart_rx_byte_sync u_sync (
        .clk       (Clk),
        .rst       (Rst),
        .rx_data   (RxData),
        .rx_done   (RxDone),
        .byte_acc  (byte_acc),
        .byte_data (byte_data)
    );

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            data_q, data_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic [7:0]            resp_data_q, resp_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [7:0]            err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  timeout;
    logic                  frame_good;
    logic                  err_inc;
    logic [LED_WIDTH-1:0]  data_w;

    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign timeout    = (state_q != ST_IDLE) && !byte_acc && (timer_q == TIMER_MAX);
    assign frame_good = (byte_data == (cmd_q ^ data_q)) && is_known_cmd(cmd_q);
    assign data_w     = data_q[LED_WIDTH-1:0];

    // State register (plus all other registered outputs).
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            cmd_q        <= '0;
            data_q       <= '0;
            led_q        <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            led_q        <= led_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (byte_acc) begin
            case (state_q)
                ST_IDLE: if (byte_data == SYNC_BYTE) state_d = ST_CMD;
                ST_CMD:  state_d = ST_DATA;
                ST_DATA: state_d = ST_CHK;
                ST_CHK:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    // Output and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        cmd_d        = cmd_q;
        data_d       = data_q;
        led_d        = led_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        err_d        = err_q;
        err_inc      = 1'b0;

        if ((state_q == ST_IDLE) || byte_acc || timeout) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (byte_acc) begin
            case (state_q)
                ST_CMD:  cmd_d  = byte_data;
                ST_DATA: data_d = byte_data;
                ST_CHK: begin
                    resp_valid_d = 1'b1;
                    if (frame_good) begin
                        resp_data_d = RESP_ACK;
                        case (cmd_q)
                            CMD_WRITE:  led_d = data_w;
                            CMD_SET:    led_d = led_q | data_w;
                            CMD_CLR:    led_d = led_q & ~data_w;
                            CMD_TOGGLE: led_d = led_q ^ data_w;
                            default:    led_d = led_q;
                        endcase
                    end else begin
                        resp_data_d = RESP_NAK;
                        err_inc     = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (timeout) err_inc = 1'b1;

        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;

        busy_d = (state_d != ST_IDLE);
    end

    assign Led       = led_q;
    assign RespData  = resp_data_q;
    assign RespValid = resp_valid_q;
    assign ErrCount  = err_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
module tb_uart_led_cmd_parser;

    logic       Clk;
    logic       Rst;
    logic [7:0] RxData;
    logic       RxDone;
    logic [7:0] Led;
    logic [7:0] RespData;
    logic       RespValid;
    logic [7:0] ErrCount;
    logic       Busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] resp;
        logic [7:0] led;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];

    uart_led_cmd_parser #(
        .LED_WIDTH      (8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RxData    (RxData),
        .RxDone    (RxDone),
        .Led       (Led),
        .RespData  (RespData),
        .RespValid (RespValid),
        .ErrCount  (ErrCount),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && RespValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got %02h expected no response", RespData);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", 32'(RespData), 32'(e.resp));
                check("resp_led",  32'(Led),      32'(e.led));
                check("resp_err",  32'(ErrCount), 32'(e.err));
            end
        end
    end

    // Receiver-like byte: done held 3 Clk, then a gap long enough for the
    // response to appear before the next byte starts.
    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        RxData = b;
        RxDone = 1'b1;
        repeat (3) @(negedge Clk);
        RxDone = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] resp, input logic [7:0] led,
                              input logic [7:0] err);
        exp_t e;
        e.resp = resp;
        e.led  = led;
        e.err  = err;
        exp_q.push_back(e);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_err;

        Rst    = 1'b1;
        RxDone = 1'b0;
        RxData = 8'h00;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        check("reset_led",        32'(Led),       32'h00);
        check("reset_resp_data",  32'(RespData),  32'h00);
        check("reset_resp_valid", 32'(RespValid), 32'h0);
        check("reset_err",        32'(ErrCount),  32'h00);
        check("reset_busy",       32'(Busy),      32'h0);

        // WRITE, CLR, TOGGLE
        send_frame(8'hA5, 8'h01, 8'h5A, 8'h5B, 8'h06, 8'h5A, 8'd0);
        send_frame(8'hA5, 8'h03, 8'h0A, 8'h09, 8'h06, 8'h50, 8'd0);
        send_frame(8'hA5, 8'h04, 8'hFF, 8'hFB, 8'h06, 8'hAF, 8'd0);

        // bad checksum, then unknown command
        send_frame(8'hA5, 8'h02, 8'hF0, 8'h00, 8'h15, 8'hAF, 8'd1);
        send_frame(8'hA5, 8'h07, 8'h00, 8'h07, 8'h15, 8'hAF, 8'd2);

        // garbage in IDLE is dropped silently
        send_byte(8'h00);
        check("garbage0_busy", 32'(Busy), 32'h0);
        send_byte(8'h33);
        check("garbage1_busy", 32'(Busy), 32'h0);
        check("garbage_err",   32'(ErrCount), 32'd2);
        begin
            exp_t e;
            e.resp = 8'h06;
            e.led  = 8'h03;
            e.err  = 8'd2;
            exp_q.push_back(e);
            send_byte(8'hA5);
            check("sync_busy", 32'(Busy), 32'h1);
            send_byte(8'h01);
            send_byte(8'h03);
            send_byte(8'h02);
        end

        // inter-byte timeout after A5,01
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (30) @(negedge Clk);
        check("timeout_busy_before", 32'(Busy), 32'h1);
        repeat (30) @(negedge Clk);
        check("timeout_busy_after", 32'(Busy), 32'h0);
        check("timeout_err",        32'(ErrCount), 32'd3);
        check("timeout_led",        32'(Led), 32'h03);
        send_frame(8'hA5, 8'h04, 8'h0F, 8'h0B, 8'h06, 8'h0C, 8'd3);

        // ErrCount saturation at 255
        exp_err = 8'd3;
        for (int i = 0; i < 257; i++) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
            send_frame(8'hA5, 8'h02, 8'hF0, 8'h00, 8'h15, 8'h0C, exp_err);
        end
        check("saturated_err", 32'(ErrCount), 32'd255);

        // reset while in DATA
        send_byte(8'hA5);
        send_byte(8'h01);
        check("pre_reset_busy", 32'(Busy), 32'h1);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("mid_reset_led",       32'(Led),      32'h00);
        check("mid_reset_err",       32'(ErrCount), 32'h00);
        check("mid_reset_busy",      32'(Busy),     32'h0);
        check("mid_reset_resp_data", 32'(RespData), 32'h00);
        repeat (10) @(negedge Clk);
        check("post_reset_idle", 32'(Busy), 32'h0);
        send_frame(8'hA5, 8'h01, 8'h81, 8'h80, 8'h06, 8'h81, 8'd0);

        repeat (20) @(negedge Clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_led_cmd_parser.md
Name: uart_led_cmd_parser

Overview:
- Consumes bytes from the UART receiver (RxData, RxDone) and assembles 4-byte command frames: SYNC, CMD, DATA, CHK.
- Applies valid LED commands to an LED register and emits a one-byte ACK or NAK response for the UART transmitter.
- Sits directly downstream of the receiver in the LED test design.
- Contains an inter-byte timeout and a saturating error counter.

Parameters:
- LED_WIDTH, 8, width of the LED register (1..8; DATA bits above LED_WIDTH are ignored).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, Clk cycles allowed between accepted bytes inside a frame (must be >= 2).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous, active-high reset.
- RxData  input  8  received byte from the UART receiver.
- RxDone  input  1  receiver done pulse, generated in the Tick domain; RxData updates on its falling edge.
- Led  output  LED_WIDTH  LED register.
- RespData  output  8  response byte: 8'h06 = ACK, 8'h15 = NAK.
- RespValid  output  1  one-Clk pulse; RespData is valid in the same cycle.
- ErrCount  output  8  saturating error count.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst). All state updates occur on posedge Clk.
- Reset values:
  - Led = 0, RespData = 0, RespValid = 0, ErrCount = 0, Busy = 0.
  - FSM = IDLE, timer = 0, synchronizer flops = 0.
  - Reset mid-frame discards the partial frame and produces no response.
- Byte acceptance:
  - RxDone passes through 2 flops (s1, s2), then a history flop s3.
  - byte_acc = s3 & ~s2, i.e. a synchronized falling edge.
  - RxData is captured in the cycle byte_acc is high. That cycle is 3 Clk after the input falling edge (±1 for metastability).
  - RxDone high for fewer than 2 Clk cycles is not guaranteed to be seen. The receiver holds it for one Tick, which is >= 2 Clk.
- FSM (CMD and DATA values are registered at acceptance):
  - IDLE: on byte_acc with byte == SYNC_BYTE -> CMD. Any other byte is dropped silently; no ErrCount change.
  - CMD: on byte_acc -> DATA. The byte is stored as cmd. SYNC_BYTE here is treated as an ordinary cmd value; there is no resync.
  - DATA: on byte_acc -> CHK. The byte is stored as data.
  - CHK: on byte_acc -> IDLE. Frame is good when the byte == cmd ^ data and cmd is in {01, 02, 03, 04}.
- Command effects (applied in the cycle after CHK acceptance):
  - 01 WRITE: Led = data.
  - 02 SET: Led |= data.
  - 03 CLR: Led &= ~data.
  - 04 TOGGLE: Led ^= data.
- Response:
  - RespValid pulses for 1 cycle, 1 Clk after CHK acceptance, in the same cycle the Led update becomes visible.
  - Good frame: RespData = 8'h06, ACK.
  - Bad checksum or unknown cmd: RespData = 8'h15, NAK. Led is unchanged and ErrCount increments.
  - RespData holds its value until the next response.
- Timeout:
  - The timer clears on every byte_acc and in IDLE. It counts in CMD, DATA and CHK.
  - When timer == TIMEOUT_CYCLES-1, the FSM returns to IDLE and ErrCount increments. No response is sent.
  - If byte_acc and timeout expiry occur in the same cycle, the byte wins: it is processed normally and the timer clears.
- ErrCount saturates at 255. An increment at 255 has no effect.
- Busy = (state != IDLE), registered with the state.
- The timer width is $clog2(TIMEOUT_CYCLES) bits; no wrap is possible before expiry.

Decomposition:
- Package uart_led_pkg holds:
  - command codes CMD_WRITE = 8'h01, CMD_SET = 8'h02, CMD_CLR = 8'h03, CMD_TOGGLE = 8'h04;
  - RESP_ACK = 8'h06 and RESP_NAK = 8'h15;
  - the FSM state encoding (IDLE, CMD, DATA, CHK as 2-bit).
- Sub-module uart_rx_byte_sync: the 2-flop synchronizer plus falling-edge detect. It outputs byte_acc and the captured byte.

Test Plan:
- Frame A5,01,5A,5B -> Led = 8'h5A; RespValid pulse with RespData = 8'h06; ErrCount = 0.
- Led = 8'h5A, then frame A5,03,0A,09 -> Led = 8'h50, ACK. Then A5,04,FF,FB -> Led = 8'hAF, ACK.
- Frame A5,02,F0,00 (bad CHK) -> NAK 8'h15, Led unchanged, ErrCount = 1. Then frame A5,07,00,07 (unknown cmd) -> NAK, ErrCount = 2.
- Bytes 00,33 in IDLE then A5,01,03,02 -> no response to the garbage bytes, Busy low until the A5, then ACK with Led = 8'h03.
- With TIMEOUT_CYCLES = 50: send A5,01 then idle for 60 cycles -> FSM returns to IDLE at cycle 50 after the 01 byte, no RespValid, ErrCount +1. A following complete frame is ACKed.
- Assert Rst during the DATA state -> Led = 0, ErrCount = 0, Busy = 0, no RespValid. A subsequent frame A5,01,81,80 is ACKed with Led = 8'h81.
